ram_maestro: RTL and testbench

- Requester-side sequencer that drives the team's single-port synchronous RAM.
- RAM interface: 8-bit address; write when enable is high; when enable is low, registered read with 1-cycle latency.
- Executes burst commands of base address and length:
  - Read bursts: RAM words go out on a valid/ready output stream.
  - Write bursts: words from a valid/ready input stream are written to RAM.
- Sits between datapath logic and the RAM; it is the only block that drives the RAM's address, data-in and enable.

---
 rtl/ram_maestro_if.sv | 41 ++++
 rtl/ram_maestro.sv | 185 ++++++++++++++++++
 tb/tb_ram_maestro.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_maestro_if.sv
// Command, RAM and stream bundle between ram_maestro and its neighbours.
// No logic and no latency; it only groups the wires.
// Backpressure travels on the ent_* and sal_* valid/ready pairs.
//
// master: the sequencer. It drives the RAM bus, the status and the stream handshakes.
// slave : the environment. It drives the command, the RAM read data and the stream inputs.
interface ram_maestro_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          inicio;
    logic          modo;
    logic [AW-1:0] dir_base;
    logic [AW-1:0] longitud;
    logic          ocupado;
    logic          hecho;
    logic [AW-1:0] ram_dir;
    logic [DW-1:0] ram_dato_e;
    logic          ram_en;
    logic [DW-1:0] ram_dato_s;
    logic [DW-1:0] ent_dato;
    logic          ent_valido;
    logic          ent_listo;
    logic [DW-1:0] sal_dato;
    logic          sal_valido;
    logic          sal_listo;

    modport master (
        input  inicio, modo, dir_base, longitud, ram_dato_s,
               ent_dato, ent_valido, sal_listo,
        output ocupado, hecho, ram_dir, ram_dato_e, ram_en,
               ent_listo, sal_dato, sal_valido
    );

    modport slave (
        output inicio, modo, dir_base, longitud, ram_dato_s,
               ent_dato, ent_valido, sal_listo,
        input  ocupado, hecho, ram_dir, ram_dato_e, ram_en,
               ent_listo, sal_dato, sal_valido
    );
endinterface

// File: rtl/ram_maestro.sv
// Burst sequencer for a single-port synchronous RAM: a read burst sends RAM words out on sal_*, and a write burst writes ent_* words into the RAM.
// Latency: a read takes 3 cycles per word and a write takes 2 cycles per word; hecho rises 1 cycle after the last word.
// Backpressure: a read word is held on sal_* until sal_listo, and a write waits in ESC_ESPERA until ent_valido.
//
// Ports: clk, rst (async, active high), bus (ram_maestro_if.master).
// The command is inicio/modo/dir_base/longitud. The status outputs are ocupado/hecho.
// The RAM bus is ram_dir/ram_dato_e/ram_en/ram_dato_s.
// Optional: when RAM_MAESTRO_SUMA_EN is defined, the output suma carries the mod-2^DW sum of the words moved by the current command.
// Every output comes straight from a flop. No input reaches an output combinationally.
module ram_maestro #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MAX_DIR = 10
) (
    input  logic            clk,
    input  logic            rst,
`ifdef RAM_MAESTRO_SUMA_EN
    output logic [DW-1:0]   suma,
`endif
    ram_maestro_if.master   bus
);

    localparam logic [AW-1:0] MAX_D = AW'(MAX_DIR);

    typedef enum logic [2:0] {
        REPOSO,
        LEE_DIR,
        LEE_ESPERA,
        LEE_ENTREGA,
        ESC_ESPERA,
        ESC_PULSO,
        FIN
    } estado_t;

    estado_t       estado_q,     estado_d;
    logic [AW-1:0] dir_actual_q, dir_actual_d;
    logic [AW-1:0] restantes_q,  restantes_d;
    logic [AW-1:0] ram_dir_q,    ram_dir_d;
    logic [DW-1:0] ram_dato_e_q, ram_dato_e_d;
    logic          ram_en_q,     ram_en_d;
    logic          ocupado_q,    ocupado_d;
    logic          hecho_q,      hecho_d;
    logic          ent_listo_q,  ent_listo_d;
    logic [DW-1:0] sal_dato_q,   sal_dato_d;
    logic          sal_valido_q, sal_valido_d;
`ifdef RAM_MAESTRO_SUMA_EN
    logic [DW-1:0] suma_q,       suma_d;
`endif

    // A start address above MAX_DIR is used once, and the following address wraps to 0.
    function automatic logic [AW-1:0] dir_sig(input logic [AW-1:0] d);
        return (d >= MAX_D) ? '0 : d + 1'b1;
    endfunction

    always_comb begin
        estado_d     = estado_q;
        dir_actual_d = dir_actual_q;
        restantes_d  = restantes_q;
        ram_dir_d    = ram_dir_q;
        ram_dato_e_d = ram_dato_e_q;
        sal_dato_d   = sal_dato_q;
        sal_valido_d = sal_valido_q;
`ifdef RAM_MAESTRO_SUMA_EN
        suma_d       = suma_q;
`endif
        case (estado_q)
            REPOSO: begin
                if (bus.inicio) begin
                    dir_actual_d = bus.dir_base;
                    restantes_d  = bus.longitud;
`ifdef RAM_MAESTRO_SUMA_EN
                    suma_d       = '0;
`endif
                    if (bus.longitud == '0) begin
                        estado_d = FIN;
                    end else if (!bus.modo) begin
                        estado_d  = LEE_DIR;
                        ram_dir_d = bus.dir_base;
                    end else begin
                        estado_d = ESC_ESPERA;
                    end
                end
            end
            LEE_DIR: begin
                estado_d = LEE_ESPERA;
            end
            LEE_ESPERA: begin
                // The RAM registered ram_dir on the previous edge, so its output is valid now.
                sal_dato_d   = bus.ram_dato_s;
                sal_valido_d = 1'b1;
                estado_d     = LEE_ENTREGA;
            end
            LEE_ENTREGA: begin
                if (bus.sal_listo) begin
                    sal_valido_d = 1'b0;
                    restantes_d  = restantes_q - 1'b1;
                    dir_actual_d = dir_sig(dir_actual_q);
`ifdef RAM_MAESTRO_SUMA_EN
                    suma_d       = suma_q + sal_dato_q;
`endif
                    if (restantes_q == AW'(1)) begin
                        estado_d = FIN;
                    end else begin
                        estado_d  = LEE_DIR;
                        ram_dir_d = dir_sig(dir_actual_q);
                    end
                end
            end
            ESC_ESPERA: begin
                if (bus.ent_valido) begin
                    ram_dir_d    = dir_actual_q;
                    ram_dato_e_d = bus.ent_dato;
`ifdef RAM_MAESTRO_SUMA_EN
                    suma_d       = suma_q + bus.ent_dato;
`endif
                    estado_d     = ESC_PULSO;
                end
            end
            ESC_PULSO: begin
                restantes_d  = restantes_q - 1'b1;
                dir_actual_d = dir_sig(dir_actual_q);
                estado_d     = (restantes_q == AW'(1)) ? FIN : ESC_ESPERA;
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        // These status outputs depend only on the next state, so each one is a clean flop output.
        ram_en_d    = (estado_d == ESC_PULSO);
        ocupado_d   = (estado_d != REPOSO);
        hecho_d     = (estado_d == FIN);
        ent_listo_d = (estado_d == ESC_ESPERA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q     <= REPOSO;
            dir_actual_q <= '0;
            restantes_q  <= '0;
            ram_dir_q    <= '0;
            ram_dato_e_q <= '0;
            ram_en_q     <= 1'b0;
            ocupado_q    <= 1'b0;
            hecho_q      <= 1'b0;
            ent_listo_q  <= 1'b0;
            sal_dato_q   <= '0;
            sal_valido_q <= 1'b0;
`ifdef RAM_MAESTRO_SUMA_EN
            suma_q       <= '0;
`endif
        end else begin
            estado_q     <= estado_d;
            dir_actual_q <= dir_actual_d;
            restantes_q  <= restantes_d;
            ram_dir_q    <= ram_dir_d;
            ram_dato_e_q <= ram_dato_e_d;
            ram_en_q     <= ram_en_d;
            ocupado_q    <= ocupado_d;
            hecho_q      <= hecho_d;
            ent_listo_q  <= ent_listo_d;
            sal_dato_q   <= sal_dato_d;
            sal_valido_q <= sal_valido_d;
`ifdef RAM_MAESTRO_SUMA_EN
            suma_q       <= suma_d;
`endif
        end
    end

    assign bus.ram_dir    = ram_dir_q;
    assign bus.ram_dato_e = ram_dato_e_q;
    assign bus.ram_en     = ram_en_q;
    assign bus.ocupado    = ocupado_q;
    assign bus.hecho      = hecho_q;
    assign bus.ent_listo  = ent_listo_q;
    assign bus.sal_dato   = sal_dato_q;
    assign bus.sal_valido = sal_valido_q;
`ifdef RAM_MAESTRO_SUMA_EN
    assign suma           = suma_q;
`endif

endmodule

// File: tb/tb_ram_maestro.sv
module tb_ram_maestro;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MAX_DIR = 10;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } ad_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ram_maestro_if #(.AW(AW), .DW(DW)) bus();
`ifdef RAM_MAESTRO_SUMA_EN
    logic [DW-1:0] suma;
`endif

    ram_maestro #(.AW(AW), .DW(DW), .MAX_DIR(MAX_DIR)) dut (
        .clk(clk),
        .rst(rst),
`ifdef RAM_MAESTRO_SUMA_EN
        .suma(suma),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with a registered read.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (bus.ram_en) ram[bus.ram_dir] <= bus.ram_dato_e;
        bus.ram_dato_s <= ram[bus.ram_dir];
    end

    // Reference model: the expected memory contents plus the expected transactions.
    logic [7:0] ref_mem [256];
    logic [7:0] saved_mem [256];
    ad_t        exp_sal[$];
    ad_t        exp_wr[$];
    logic [7:0] ent_q[$];
    logic [7:0] wdat[$];
    logic [7:0] exp_sum = '0;
    int         pend = 0;

    // Observations made by the compare process.
    logic [7:0] got_sal[$];
    logic [7:0] got_dir[$];
    logic [7:0] got_wr[$];
    int         hs_cyc[$];
    int         wr_cyc[$];
    int         hecho_cnt = 0;
    int         hecho_cyc = 0;
    int         occ_cnt = 0;
    int         stall_cnt = 0;
    int         ent_hs_cnt = 0;
    int         ent_popped = 0;
    int         issue_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dato = '0;
    logic [7:0] prev_dir = '0;

    // Stimulus controls.
    int         sal_block = 0;
    logic       sal_rand = 1'b0;
    logic       ent_gap = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] a);
        return (a >= 8'(MAX_DIR)) ? 8'd0 : a + 8'd1;
    endfunction

    task automatic clear_obs();
        got_sal.delete(); got_dir.delete(); got_wr.delete();
        hs_cyc.delete(); wr_cyc.delete();
        stall_cnt = 0;
    endtask

    // Must be called at posedge+1 while the DUT is idle.
    task automatic issue(input logic m, input logic [7:0] base, input logic [7:0] len);
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] s;
        a = base;
        s = '0;
        for (int i = 0; i < int'(len); i++) begin
            if (!m) begin
                exp_sal.push_back(ad_t'({a, ref_mem[a]}));
                s = s + ref_mem[a];
            end else begin
                if (wdat.size() > 0) d = wdat.pop_front();
                else d = 8'($urandom);
                exp_wr.push_back(ad_t'({a, d}));
                ent_q.push_back(d);
                ref_mem[a] = d;
                s = s + d;
            end
            a = nxt(a);
        end
        exp_sum = s;
        pend++;
        issue_cyc = cyc;
        bus.inicio = 1'b1;
        bus.modo = m;
        bus.dir_base = base;
        bus.longitud = len;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = hecho_cnt;
        n = 0;
        while (hecho_cnt == start && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_in_time", 32'(hecho_cnt != start), 1);
    endtask

    // Input driver: acts at posedge+1.
    always @(posedge clk) begin
        #1;
        while (ent_popped < ent_hs_cnt) begin
            if (ent_q.size() > 0) ent_q.delete(0);
            ent_popped++;
        end
        if (ent_q.size() > 0 && (!ent_gap || $urandom_range(0, 2) != 0)) begin
            bus.ent_valido = 1'b1;
            bus.ent_dato = ent_q[0];
        end else begin
            bus.ent_valido = 1'b0;
            bus.ent_dato = 8'($urandom);
        end
        if (sal_block > 0) begin
            bus.sal_listo = 1'b0;
            if (bus.sal_valido) sal_block--;
        end else begin
            bus.sal_listo = sal_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: samples the DUT outputs at the negative edge.
    always @(negedge clk) begin
        ad_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valido", bus.sal_valido, 1);
                chk("hold_dato", bus.sal_dato, prev_dato);
                chk("hold_dir", bus.ram_dir, prev_dir);
            end
            prev_stall = bus.sal_valido && !bus.sal_listo;
            prev_dato = bus.sal_dato;
            prev_dir = bus.ram_dir;
            if (prev_stall) stall_cnt++;
            if (bus.sal_valido && bus.sal_listo) begin
                got_sal.push_back(bus.sal_dato);
                got_dir.push_back(bus.ram_dir);
                hs_cyc.push_back(cyc);
                if (exp_sal.size() == 0) chk("sal_unexpected", 1, 0);
                else begin
                    e = exp_sal.pop_front();
                    chk("sal_dato", bus.sal_dato, e.d);
                    chk("sal_dir", bus.ram_dir, e.a);
                end
            end
            if (bus.ram_en) begin
                got_wr.push_back(bus.ram_dir);
                wr_cyc.push_back(cyc);
                if (exp_wr.size() == 0) chk("ram_en_unexpected", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_dir", bus.ram_dir, e.a);
                    chk("wr_dato", bus.ram_dato_e, e.d);
                end
            end
            if (bus.ent_valido && bus.ent_listo) ent_hs_cnt++;
            if (bus.ocupado) begin
                occ_cnt++;
                chk("ocupado_without_cmd", 32'(pend > 0), 1);
            end
            if (bus.hecho) begin
                hecho_cnt++;
                hecho_cyc = cyc;
                chk("hecho_expected", 32'(pend > 0), 1);
                chk("hecho_sal_drained", exp_sal.size(), 0);
                chk("hecho_wr_drained", exp_wr.size(), 0);
`ifdef RAM_MAESTRO_SUMA_EN
                chk("suma", suma, exp_sum);
`endif
                pend--;
            end
        end
    end

    initial begin
        int n;
        int h0;
        int o0;
        logic [7:0] pre [11];
        pre = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd100, 8'd101};
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = (i < 11) ? pre[i] : 8'($urandom);
            ram[i] <= v;
            ref_mem[i] = v;
        end
        bus.inicio = 1'b0; bus.modo = 1'b0; bus.dir_base = '0; bus.longitud = '0;
        bus.ent_dato = '0; bus.ent_valido = 1'b0; bus.sal_listo = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ocupado", bus.ocupado, 0);
        chk("rst_hecho", bus.hecho, 0);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_dir", bus.ram_dir, 0);
        chk("rst_sal_valido", bus.sal_valido, 0);
        chk("rst_ent_listo", bus.ent_listo, 0);
        chk("rst_sal_dato", bus.sal_dato, 0);
        chk("rst_ram_dato_e", bus.ram_dato_e, 0);
`ifdef RAM_MAESTRO_SUMA_EN
        chk("rst_suma", suma, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Read 0..2 with no backpressure.
        clear_obs();
        issue(1'b0, 8'd0, 8'd3);
        wait_done();
        chk("t1_n", got_sal.size(), 3);
        chk("t1_w0", got_sal[0], 90);
        chk("t1_w1", got_sal[1], 80);
        chk("t1_w2", got_sal[2], 70);
        chk("t1_rate01", hs_cyc[1] - hs_cyc[0], 3);
        chk("t1_rate12", hs_cyc[2] - hs_cyc[1], 3);
        chk("t1_hecho_lat", hecho_cyc - hs_cyc[2], 1);
        chk("t1_no_wr", got_wr.size(), 0);

        // Write 0xAA, 0x55 to 4..5, then read them back.
        clear_obs();
        wdat.push_back(8'hAA); wdat.push_back(8'h55);
        issue(1'b1, 8'd4, 8'd2);
        wait_done();
        chk("t2_nwr", got_wr.size(), 2);
        chk("t2_a0", got_wr[0], 4);
        chk("t2_a1", got_wr[1], 5);
        chk("t2_rate", wr_cyc[1] - wr_cyc[0], 2);
        clear_obs();
        issue(1'b0, 8'd4, 8'd2);
        wait_done();
        chk("t2_r0", got_sal[0], 8'hAA);
        chk("t2_r1", got_sal[1], 8'h55);

        // The address wraps past MAX_DIR.
        clear_obs();
        issue(1'b0, 8'd9, 8'd4);
        wait_done();
        chk("t3_d0", got_dir[0], 9);
        chk("t3_d1", got_dir[1], 10);
        chk("t3_d2", got_dir[2], 0);
        chk("t3_d3", got_dir[3], 1);
        chk("t3_w0", got_sal[0], 100);
        chk("t3_w1", got_sal[1], 101);
        chk("t3_w2", got_sal[2], 90);
        chk("t3_w3", got_sal[3], 80);

        // Backpressure on the first word, plus an inicio pulse during the burst that must be ignored.
        clear_obs();
        sal_block = 5;
        h0 = hecho_cnt;
        issue(1'b0, 8'd0, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        bus.inicio = 1'b1; bus.modo = 1'b1; bus.longitud = 8'd7;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        chk("t4_stall", stall_cnt, 5);
        chk("t4_w0", got_sal[0], 90);
        chk("t4_n", got_sal.size(), 3);
        chk("t4_one_hecho", hecho_cnt - h0, 1);
        chk("t4_idle", bus.ocupado, 0);

        // A zero-length command.
        clear_obs();
        o0 = occ_cnt;
        issue(1'b0, 8'd5, 8'd0);
        wait_done();
        chk("t5_hecho_lat", hecho_cyc - issue_cyc, 1);
        chk("t5_ocupado", occ_cnt - o0, 1);
        chk("t5_no_sal", got_sal.size(), 0);
        chk("t5_no_wr", got_wr.size(), 0);

        // Asynchronous reset asserted during ESC_PULSO.
        saved_mem = ref_mem;
        issue(1'b1, 8'd3, 8'd3);
        n = 0;
        while (!bus.ram_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_pulso", bus.ram_en, 1);
        h0 = hecho_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ram_en", bus.ram_en, 0);
        chk("t6_ocupado", bus.ocupado, 0);
        chk("t6_ram_dir", bus.ram_dir, 0);
        chk("t6_ram_dato_e", bus.ram_dato_e, 0);
        chk("t6_ent_listo", bus.ent_listo, 0);
        chk("t6_hecho", bus.hecho, 0);
        ref_mem = saved_mem;
        exp_wr.delete(); exp_sal.delete(); ent_q.delete();
        pend = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_no_hecho", hecho_cnt, h0);
        clear_obs();
        issue(1'b0, 8'd3, 8'd3);
        wait_done();
        chk("t6_after_n", got_sal.size(), 3);
        issue(1'b1, 8'd3, 8'd2);
        wait_done();
        issue(1'b0, 8'd2, 8'd4);
        wait_done();

        // Random commands with random stalls on both streams.
        sal_rand = 1'b1;
        ent_gap = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] b;
            logic [7:0] l;
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(11, 255)) : 8'($urandom_range(0, MAX_DIR));
            l = 8'($urandom_range(0, 24));
            issue(1'($urandom_range(0, 1)), b, l);
            wait_done();
        end
        repeat (3) @(posedge clk);
        #1;
        chk("end_pending", pend, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
